// File: rtl/mem_arbiter_pkg.sv
// Shared types for the icache/dcache AXI bus arbiter.
// Holds the arbiter state encoding and the owner flag values.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    I_RD = 2'd1,
    D_RD = 2'd2,
    D_WR = 2'd3
  } arb_state_t;

  localparam logic OWNER_ICACHE = 1'b0;
  localparam logic OWNER_DCACHE = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin icache/dcache arbiter for a shared AXI master port.
// Ports: clk, reset (async low); icache_req, dcache_req,
//   dcache_is_write in; icache_grant, dcache_grant out;
//   AR/R/B handshake monitors in; bus_busy, proto_err out.
import mem_arbiter_pkg::*;

module mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int LEN_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             icache_req,
  input  logic             dcache_req,
  input  logic             dcache_is_write,
  output logic             icache_grant,
  output logic             dcache_grant,
  input  logic             m_axi_arvalid,
  input  logic             m_axi_arready,
  input  logic [LEN_W-1:0] m_axi_arlen,
  input  logic             m_axi_rvalid,
  input  logic             m_axi_rready,
  input  logic             m_axi_rlast,
  input  logic             m_axi_bvalid,
  input  logic             m_axi_bready,
  output logic             bus_busy,
  output logic             proto_err
);

  // The address width only documents the attached bus.
  if (ADDR_W < 1) begin : g_bad_addr_w
    $error("ADDR_W must be positive");
  end

  arb_state_t       state_q, state_d;
  logic             last_owner_q, last_owner_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             proto_err_q, proto_err_d;

  logic ar_hs;
  logic r_beat;
  logic b_hs;
  logic pick_d;

  assign ar_hs  = m_axi_arvalid & m_axi_arready;
  assign r_beat = m_axi_rvalid & m_axi_rready;
  assign b_hs   = m_axi_bvalid & m_axi_bready;

  // dcache wins when alone, or on a tie if icache went last.
  assign pick_d = dcache_req &
    (!icache_req || last_owner_q == OWNER_ICACHE);

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    proto_err_d  = proto_err_q;
    unique case (state_q)
      IDLE: begin
        // Each grant starts with no AR seen yet.
        beat_cnt_d = '0;
        if (pick_d) begin
          state_d      = dcache_is_write ? D_WR : D_RD;
          last_owner_d = OWNER_DCACHE;
        end else if (icache_req) begin
          state_d      = I_RD;
          last_owner_d = OWNER_ICACHE;
        end
      end
      I_RD, D_RD: begin
        if (ar_hs) begin
          beat_cnt_d = m_axi_arlen;
        end else if (r_beat && !m_axi_rlast &&
                     beat_cnt_q != '0) begin
          beat_cnt_d = beat_cnt_q - LEN_W'(1);
        end
        if (r_beat) begin
          if (m_axi_rlast) begin
            // rlast always ends the grant, error or not.
            state_d = IDLE;
            if (beat_cnt_q != '0) proto_err_d = 1'b1;
          end else if (beat_cnt_q == '0) begin
            proto_err_d = 1'b1;
          end
        end
      end
      D_WR: begin
        if (b_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_owner_q <= OWNER_ICACHE;
      beat_cnt_q   <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign icache_grant = (state_q == I_RD);
  assign dcache_grant = (state_q == D_RD) || (state_q == D_WR);
  assign bus_busy     = (state_q != IDLE);
  assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios
// plus randomized traffic against a transaction-level model.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       icache_req, dcache_req, dcache_is_write;
  logic       icache_grant, dcache_grant;
  logic       arvalid, arready;
  logic [7:0] arlen;
  logic       rvalid, rready, rlast;
  logic       bvalid, bready;
  logic       bus_busy, proto_err;

  int total = 0;
  int bad   = 0;

  // Model: who owns the bus (0 none, 1 icache read,
  // 2 dcache read, 3 dcache write), who went last, the
  // announced burst length and beats seen so far.
  int m_own;
  int m_last_dc;
  int m_len;
  int m_seen;
  bit m_err;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(64), .LEN_W(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .icache_req      (icache_req),
    .dcache_req      (dcache_req),
    .dcache_is_write (dcache_is_write),
    .icache_grant    (icache_grant),
    .dcache_grant    (dcache_grant),
    .m_axi_arvalid   (arvalid),
    .m_axi_arready   (arready),
    .m_axi_arlen     (arlen),
    .m_axi_rvalid    (rvalid),
    .m_axi_rready    (rready),
    .m_axi_rlast     (rlast),
    .m_axi_bvalid    (bvalid),
    .m_axi_bready    (bready),
    .bus_busy        (bus_busy),
    .proto_err       (proto_err)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic clear_inputs();
    icache_req = 0; dcache_req = 0; dcache_is_write = 0;
    arvalid = 0; arready = 0; arlen = 0;
    rvalid = 0; rready = 0; rlast = 0;
    bvalid = 0; bready = 0;
  endtask

  task automatic model_reset();
    m_own = 0; m_last_dc = 0;
    m_len = 0; m_seen = 0; m_err = 0;
  endtask

  // Advance the model by one clock using the driven inputs.
  task automatic model_step();
    int win;
    if (m_own == 0) begin
      win = 0;
      if (icache_req && dcache_req)
        win = m_last_dc ? 1 : 2;
      else if (icache_req) win = 1;
      else if (dcache_req) win = 2;
      if (win == 1) begin
        m_own = 1; m_last_dc = 0;
      end else if (win == 2) begin
        m_own = dcache_is_write ? 3 : 2; m_last_dc = 1;
      end
      m_len = 0; m_seen = 0;
    end else if (m_own == 3) begin
      if (bvalid && bready) m_own = 0;
    end else begin
      if (rvalid && rready) begin
        if (rlast) begin
          if (m_seen < m_len) m_err = 1;
          m_own = 0;
        end else begin
          if (m_seen >= m_len) m_err = 1;
          m_seen++;
        end
      end
      if (arvalid && arready) begin
        m_len = int'(arlen); m_seen = 0;
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1;
  endtask

  task automatic do_ar(input int len);
    arvalid = 1; arready = 1; arlen = 8'(len);
    step();
    arvalid = 0; arready = 0;
  endtask

  task automatic do_beat(input bit last);
    rvalid = 1; rready = 1; rlast = last;
    step();
    rvalid = 0; rready = 0; rlast = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 0;
    model_reset();
    #12;
    total++;
    if ({icache_grant, dcache_grant, bus_busy, proto_err}
        !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outs got=%b want=0000",
        {icache_grant, dcache_grant, bus_busy, proto_err});
    end
    @(posedge clk);
    #1;
    reset = 1;
  endtask

  task automatic test_icache_burst();
    icache_req = 1;
    step();
    icache_req = 0;
    total++;
    if ({icache_grant, dcache_grant, bus_busy} !== 3'b101) begin
      bad++;
      $display("FAIL ic_grant got=%b want=101",
        {icache_grant, dcache_grant, bus_busy});
    end
    do_ar(7);
    for (int b = 0; b < 8; b++) begin
      do_beat(b == 7);
      total++;
      if (icache_grant !== (b != 7)) begin
        bad++;
        $display("FAIL ic_beat%0d got=%b want=%b",
          b, icache_grant, b != 7);
      end
    end
    total++;
    if ({bus_busy, proto_err} !== 2'b00) begin
      bad++;
      $display("FAIL ic_done got=%b want=00",
        {bus_busy, proto_err});
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    icache_req = 1; dcache_req = 1; dcache_is_write = 0;
    step();
    total++;
    if ({icache_grant, dcache_grant} !== 2'b01) begin
      bad++;
      $display("FAIL rr_first got=%b want=01",
        {icache_grant, dcache_grant});
    end
    do_ar(0);
    do_beat(1);
    total++;
    if (bus_busy !== 1'b0) begin
      bad++;
      $display("FAIL rr_gap got=%b want=0", bus_busy);
    end
    step();
    total++;
    if ({icache_grant, dcache_grant} !== 2'b10) begin
      bad++;
      $display("FAIL rr_second got=%b want=10",
        {icache_grant, dcache_grant});
    end
    do_ar(0);
    do_beat(1);
    step();
    total++;
    if ({icache_grant, dcache_grant} !== 2'b01) begin
      bad++;
      $display("FAIL rr_third got=%b want=01",
        {icache_grant, dcache_grant});
    end
    icache_req = 0; dcache_req = 0;
    do_ar(0);
    do_beat(1);
    step();
  endtask

  task automatic test_write();
    dcache_req = 1; dcache_is_write = 1;
    step();
    dcache_req = 0; dcache_is_write = 0;
    do_beat(1);
    total++;
    if ({dcache_grant, proto_err} !== 2'b10) begin
      bad++;
      $display("FAIL wr_rlast_ignored got=%b want=10",
        {dcache_grant, proto_err});
    end
    bvalid = 1; bready = 1;
    step();
    bvalid = 0; bready = 0;
    total++;
    if (bus_busy !== 1'b0) begin
      bad++;
      $display("FAIL wr_done got=%b want=0", bus_busy);
    end
    step();
  endtask

  task automatic test_req_drop();
    icache_req = 1;
    step();
    icache_req = 0;
    do_ar(1);
    step();
    step();
    do_beat(0);
    total++;
    if (icache_grant !== 1'b1) begin
      bad++;
      $display("FAIL drop_held got=%b want=1", icache_grant);
    end
    do_beat(1);
    total++;
    if (icache_grant !== 1'b0) begin
      bad++;
      $display("FAIL drop_release got=%b want=0",
        icache_grant);
    end
    step();
  endtask

  task automatic test_proto_err();
    icache_req = 1;
    step();
    icache_req = 0;
    do_ar(3);
    do_beat(0);
    total++;
    if (proto_err !== 1'b0) begin
      bad++;
      $display("FAIL perr_early got=%b want=0", proto_err);
    end
    do_beat(1);
    total++;
    if ({proto_err, bus_busy} !== 2'b10) begin
      bad++;
      $display("FAIL perr_set got=%b want=10",
        {proto_err, bus_busy});
    end
    step();
    icache_req = 1;
    step();
    icache_req = 0;
    do_ar(1);
    do_beat(0);
    do_beat(1);
    total++;
    if ({proto_err, bus_busy} !== 2'b10) begin
      bad++;
      $display("FAIL perr_sticky got=%b want=10",
        {proto_err, bus_busy});
    end
    step();
  endtask

  task automatic test_reset_mid_burst();
    icache_req = 1;
    step();
    icache_req = 0;
    do_ar(7);
    do_beat(0);
    do_beat(0);
    rvalid = 1; rready = 1;
    #2;
    reset = 0;
    model_reset();
    #1;
    total++;
    if ({icache_grant, dcache_grant, bus_busy, proto_err}
        !== 4'b0000) begin
      bad++;
      $display("FAIL midrst_outs got=%b want=0000",
        {icache_grant, dcache_grant, bus_busy, proto_err});
    end
    clear_inputs();
    @(posedge clk);
    #1;
    reset = 1;
    icache_req = 1;
    step();
    icache_req = 0;
    total++;
    if (icache_grant !== 1'b1) begin
      bad++;
      $display("FAIL midrst_regrant got=%b want=1",
        icache_grant);
    end
    do_ar(0);
    do_beat(1);
    total++;
    if ({bus_busy, proto_err} !== 2'b00) begin
      bad++;
      $display("FAIL midrst_clean got=%b want=00",
        {bus_busy, proto_err});
    end
  endtask

  task automatic test_random();
    logic [3:0] exp;
    logic [3:0] got;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      icache_req      = ($urandom_range(0, 2) == 0);
      dcache_req      = ($urandom_range(0, 2) == 0);
      dcache_is_write = $urandom_range(0, 1) == 1;
      arvalid = ($urandom_range(0, 3) == 0);
      arready = $urandom_range(0, 1) == 1;
      arlen   = 8'($urandom_range(0, 5));
      rvalid  = $urandom_range(0, 1) == 1;
      rready  = ($urandom_range(0, 3) != 0);
      rlast   = ($urandom_range(0, 4) == 0);
      bvalid  = ($urandom_range(0, 3) == 0);
      bready  = $urandom_range(0, 1) == 1;
      step();
      exp = {m_own == 1, m_own == 2 || m_own == 3,
             m_own != 0, m_err};
      got = {icache_grant, dcache_grant, bus_busy, proto_err};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL rand_cyc%0d got=%b want=%b",
          c, got, exp);
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_icache_burst();
    test_round_robin();
    test_write();
    test_req_drop();
    test_proto_err();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
